// File: rtl/generation_step_controller.sv
// rtl/generation_step_controller.sv - generation-advance strobe controller; STEP_CTRL_OVERRUN_COUNT_EN adds overrun_count
module generation_step_controller #(
    parameter int TICK_DIV        = 1000000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_switch,
    input  logic       step_button,
    input  logic [1:0] speed_sel,
    input  logic       gen_ready,
    output logic       gen_tick,
    output logic       running
`ifdef STEP_CTRL_OVERRUN_COUNT_EN
    ,
    output logic [7:0] overrun_count
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic          run_meta_q, run_meta_d;
    logic          run_s_q, run_s_d;
    logic          step_meta_q, step_meta_d;
    logic          step_s_q, step_s_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_level_q, db_level_d;
    state_t        state_q, state_d;
    logic          running_q, running_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    intv_q, intv_d;
    logic          pending_q, pending_d;
    logic          gen_tick_q, gen_tick_d;

    logic          step_req;
    logic          rate_req;
    logic          base_tick;
    logic          enter_run;
    logic          req;
    logic [2:0]    intv_lim;

    // Two-flop synchronizers and the step-button debouncer
    always_comb begin
        run_meta_d  = run_switch;
        run_s_d     = run_meta_q;
        step_meta_d = step_button;
        step_s_d    = step_meta_q;
        db_cnt_d    = '0;
        db_level_d  = db_level_q;
        step_req    = 1'b0;
        if (step_s_q != db_level_q) begin
            if (db_cnt_q == DB_MAX) begin
                db_level_d = step_s_q;
                step_req   = step_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Register the synchronizer and debounce state
    always_ff @(posedge clk) begin
        if (reset) begin
            run_meta_q  <= 1'b0;
            run_s_q     <= 1'b0;
            step_meta_q <= 1'b0;
            step_s_q    <= 1'b0;
            db_cnt_q    <= '0;
            db_level_q  <= 1'b0;
        end else begin
            run_meta_q  <= run_meta_d;
            run_s_q     <= run_s_d;
            step_meta_q <= step_meta_d;
            step_s_q    <= step_s_d;
            db_cnt_q    <= db_cnt_d;
            db_level_q  <= db_level_d;
        end
    end

    // Run/pause state register; running is registered alongside so it tracks the state exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
        end
    end

    // Next state follows the synchronized run switch
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PAUSE: if (run_s_q)  state_d = ST_RUN;
            ST_RUN:   if (!run_s_q) state_d = ST_PAUSE;
            default:  state_d = ST_PAUSE;
        endcase
    end

    // FSM outputs: running reflects the state being entered
    always_comb begin
        running_d = (state_d == ST_RUN);
        enter_run = (state_q == ST_PAUSE) && (state_d == ST_RUN);
    end

    // Prescaler and interval counter; a lowered limit takes effect at the very next base tick
    always_comb begin
        intv_lim  = 3'((4'd8 >> speed_sel) - 4'd1);
        base_tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
        presc_d   = presc_q;
        intv_d    = intv_q;
        rate_req  = 1'b0;
        if (enter_run) begin
            presc_d = '0;
            intv_d  = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = base_tick ? '0 : presc_q + 1'b1;
            if (base_tick) begin
                if (intv_q >= intv_lim) begin
                    intv_d   = '0;
                    rate_req = 1'b1;
                end else begin
                    intv_d = intv_q + 3'd1;
                end
            end
        end
    end

    // Register the rate counters
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            intv_q  <= '0;
        end else begin
            presc_q <= presc_d;
            intv_q  <= intv_d;
        end
    end

    // Request select and ready handshake; extra requests while one is held are coalesced
    always_comb begin
        req        = (state_q == ST_RUN) ? rate_req : step_req;
        gen_tick_d = 1'b0;
        pending_d  = pending_q | req;
        if (gen_ready && (pending_q || req)) begin
            gen_tick_d = 1'b1;
            pending_d  = 1'b0;
        end
    end

    // Register the strobe and the held request
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= 1'b0;
            gen_tick_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            gen_tick_q <= gen_tick_d;
        end
    end

`ifdef STEP_CTRL_OVERRUN_COUNT_EN
    logic [7:0] overrun_q, overrun_d;

    // Count requests that land on an undelivered one; a request while the held one drains is not counted
    always_comb begin
        overrun_d = overrun_q;
        if (req && pending_q && !gen_ready && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    // Register the saturating overrun counter
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 8'd0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_count = overrun_q;
`endif

    assign gen_tick = gen_tick_q;
    assign running  = running_q;

endmodule
